// File: rtl/lenet_pkg.sv
// Shared LeNet layer geometry: default image/kernel sizes
// plus helpers for derived widths, used by conv, MAC and pooling.
package lenet_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int K_DEF     = 5;
  localparam int DW_DEF    = 8;

  function automatic int ow_f(input int w, input int k);
    return w - k + 1;
  endfunction

  // Never return a zero width for a 1-entry range
  function automatic int cw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_delay.sv
// DEPTH-deep delay line, advanced only on en_i.
// RAM with a wrap pointer: read old word, overwrite with new.
module line_delay
  import lenet_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = IMG_W_DEF,
  localparam int AW   = cw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  assign dout_o = mem_q[ptr_q];

  assign ptr_d = (ptr_q == AW'(DEPTH - 1))
               ? '0 : ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK stride-1 window generator over a raster
// pixel stream, using K-1 chained line delays.
module conv_window_gen
  import lenet_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF,
  parameter int DW    = DW_DEF,
  localparam int OW   = ow_f(IMG_W, K),
  localparam int RW   = cw_f(IMG_H - K + 1),
  localparam int CW   = cw_f(OW),
  localparam int XW   = cw_f(IMG_W),
  localparam int YW   = cw_f(IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win_data,
  output logic [RW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic              frame_done
);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic          col_end, row_end, hit;

  logic [DW-1:0] ld_out [K-1];
  logic [DW-1:0] col_new [K];
  logic [DW-1:0] win_q [K][K];
  logic [DW-1:0] win_d [K][K];
  logic [K*K*DW-1:0] win_flat;

  logic              win_valid_q, frame_done_q;
  logic [K*K*DW-1:0] win_data_q;
  logic [RW-1:0]     win_row_q, win_row_d;
  logic [CW-1:0]     win_col_q, win_col_d;

  assign col_end = (col_q == XW'(IMG_W - 1));
  assign row_end = (row_q == YW'(IMG_H - 1));
  assign col_d   = col_end ? '0 : col_q + XW'(1);
  assign row_d   = !col_end ? row_q
                 : (row_end ? '0 : row_q + YW'(1));

  // Window complete once K-1 rows and cols precede this pixel
  assign hit = in_valid
            && (row_q >= YW'(K - 1))
            && (col_q >= XW'(K - 1));

  assign win_row_d = RW'(row_q - YW'(K - 1));
  assign win_col_d = CW'(col_q - XW'(K - 1));

  for (genvar j = 0; j < K - 1; j++) begin : g_ld
    logic [DW-1:0] ld_in;
    if (j == 0) begin : g_head
      assign ld_in = in_data;
    end else begin : g_chain
      assign ld_in = ld_out[j-1];
    end
    line_delay #(
      .DW    (DW),
      .DEPTH (IMG_W)
    ) u_ld (
      .clk    (clk),
      .reset  (reset),
      .en_i   (in_valid),
      .din_i  (ld_in),
      .dout_o (ld_out[j])
    );
  end

  // Oldest row (deepest delay) lands in window row 0
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign col_new[r] = ld_out[K-2-r];
  end
  assign col_new[K-1] = in_data;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = col_new[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*DW +: DW] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_valid_q  <= hit;
      frame_done_q <= hit && row_end && col_end;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        win_q <= win_d;
      end
      if (hit) begin
        win_data_q <= win_flat;
        win_row_q  <= win_row_d;
        win_col_q  <= win_col_d;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: image-level window model for a
// 32x32/K5 and an 8x8/K3 instance, plus literal spot checks.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         iv_a = 1'b0;
  logic [7:0]   d_a = '0;
  logic         wv_a, fd_a;
  logic [199:0] wd_a;
  logic [4:0]   wr_a, wc_a;

  logic         iv_b = 1'b0;
  logic [7:0]   d_b = '0;
  logic         wv_b, fd_b;
  logic [71:0]  wd_b;
  logic [2:0]   wr_b, wc_b;

  int checks = 0;
  int errors = 0;

  conv_window_gen u_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv_a),
    .in_data    (d_a),
    .win_valid  (wv_a),
    .win_data   (wd_a),
    .win_row    (wr_a),
    .win_col    (wc_a),
    .frame_done (fd_a)
  );

  conv_window_gen #(
    .IMG_W (8),
    .IMG_H (8),
    .K     (3),
    .DW    (8)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (iv_b),
    .in_data    (d_b),
    .win_valid  (wv_b),
    .win_data   (wd_b),
    .win_row    (wr_b),
    .win_col    (wc_b),
    .frame_done (fd_b)
  );

  // Model: store the frame image, build each window from it
  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int W  = (g == 0) ? 32 : 8;
    localparam int H  = (g == 0) ? 32 : 8;
    localparam int KK = (g == 0) ? 5 : 3;
    logic [7:0]   img [32][32];
    int           cnt = 0;
    logic         ev = 1'b0;
    logic         efd = 1'b0;
    int           er = 0;
    int           ec = 0;
    logic [199:0] ed = '0;
    logic         iv;
    logic [7:0]   dd;
    assign iv = (g == 0) ? iv_a : iv_b;
    assign dd = (g == 0) ? d_a : d_b;

    always @(posedge clk or posedge reset) begin
      int r, c;
      if (reset) begin
        cnt = 0; ev = 0; efd = 0;
        er = 0; ec = 0; ed = '0;
      end else if (iv) begin
        r = cnt / W;
        c = cnt % W;
        img[r][c] = dd;
        if (r >= KK - 1 && c >= KK - 1) begin
          ev  = 1'b1;
          efd = (r == H - 1) && (c == W - 1);
          er  = r - KK + 1;
          ec  = c - KK + 1;
          ed  = '0;
          for (int rr = 0; rr < KK; rr++)
            for (int cc = 0; cc < KK; cc++)
              ed[(rr*KK+cc)*8 +: 8] = img[er+rr][ec+cc];
        end else begin
          ev = 1'b0;
          efd = 1'b0;
        end
        cnt = (cnt + 1) % (W * H);
      end else begin
        ev = 1'b0;
        efd = 1'b0;
      end
    end
  end

  task automatic chk(input string n,
                     input logic [199:0] act,
                     input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  int           pulses_a = 0, frames_a = 0, first_idx_a = 0;
  logic [199:0] first_wd_a = '0, last_wd_a = '0;
  logic [4:0]   last_r_a = '0, last_c_a = '0;
  logic         last_fd_a = 1'b0;
  int           pulses_b = 0, first_idx_b = 0;
  logic [71:0]  first_wd_b = '0;
  logic [2:0]   last_r_b = '0, last_c_b = '0;
  logic         last_fd_b = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("a_valid", 200'(wv_a), 200'(gm[0].ev));
      chk("a_done", 200'(fd_a), 200'(gm[0].efd));
      chk("a_row", 200'(wr_a), 200'(gm[0].er));
      chk("a_col", 200'(wc_a), 200'(gm[0].ec));
      chk("a_data", wd_a, gm[0].ed);
      chk("b_valid", 200'(wv_b), 200'(gm[1].ev));
      chk("b_done", 200'(fd_b), 200'(gm[1].efd));
      chk("b_row", 200'(wr_b), 200'(gm[1].er));
      chk("b_col", 200'(wc_b), 200'(gm[1].ec));
      chk("b_data", 200'(wd_b), gm[1].ed);
      if (wv_a) begin
        pulses_a++;
        if (fd_a) frames_a++;
        if (wr_a == 0 && wc_a == 0) begin
          first_idx_a = gm[0].cnt;
          first_wd_a  = wd_a;
        end
        last_wd_a = wd_a;
        last_r_a  = wr_a;
        last_c_a  = wc_a;
        last_fd_a = fd_a;
      end
      if (wv_b) begin
        pulses_b++;
        if (wr_b == 0 && wc_b == 0) begin
          first_idx_b = gm[1].cnt;
          first_wd_b  = wd_b;
        end
        last_r_b  = wr_b;
        last_c_b  = wc_b;
        last_fd_b = fd_b;
      end
    end
  end

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      iv_a = 1'b0;
    end
  endtask

  task automatic send_a(input int n, input bit inv, input int gap);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        @(negedge clk);
        iv_a = 1'b0;
      end
      @(negedge clk);
      v = i[7:0];
      iv_a = 1'b1;
      d_a = inv ? ~v : v;
    end
  endtask

  task automatic chk_outs_zero(input string n);
    chk({n, "_valid"}, 200'(wv_a), '0);
    chk({n, "_done"}, 200'(fd_a), '0);
    chk({n, "_data"}, wd_a, '0);
    chk({n, "_rowcol"}, 200'({wr_a, wc_a}), '0);
  endtask

  int p0, f0;
  logic [199:0] ramp_first, ramp_last;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    chk("reset_b", 200'({wv_b, fd_b, wd_b, wr_b, wc_b}), '0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Continuous ramp frame
    p0 = pulses_a; f0 = frames_a;
    send_a(1024, 1'b0, 0);
    idle_a(4);
    chk("ramp_pulses", 200'(pulses_a - p0), 200'(784));
    chk("ramp_frames", 200'(frames_a - f0), 200'(1));
    chk("ramp_first_idx", 200'(first_idx_a), 200'(133));
    chk("ramp_w00", 200'(first_wd_a[7:0]), 200'(0));
    chk("ramp_w04", 200'(first_wd_a[39:32]), 200'(4));
    chk("ramp_w40", 200'(first_wd_a[167:160]), 200'(128));
    chk("ramp_w44", 200'(first_wd_a[199:192]), 200'(132));
    chk("ramp_last_rc", 200'({last_r_a, last_c_a}),
        200'({5'd27, 5'd27}));
    chk("ramp_last_fd", 200'(last_fd_a), 200'(1));
    chk("ramp_last_w44", 200'(last_wd_a[199:192]), 200'(8'hFF));
    ramp_first = first_wd_a;
    ramp_last  = last_wd_a;

    // Same frame with ~50% valid duty
    p0 = pulses_a;
    send_a(1024, 1'b0, 50);
    idle_a(4);
    chk("gap_pulses", 200'(pulses_a - p0), 200'(784));
    chk("gap_first_idx", 200'(first_idx_a), 200'(133));
    chk("gap_first", first_wd_a, ramp_first);
    chk("gap_last", last_wd_a, ramp_last);

    // Back-to-back: ramp then inverted ramp
    p0 = pulses_a; f0 = frames_a;
    send_a(1024, 1'b0, 0);
    send_a(1024, 1'b1, 0);
    idle_a(4);
    chk("b2b_pulses", 200'(pulses_a - p0), 200'(1568));
    chk("b2b_frames", 200'(frames_a - f0), 200'(2));
    chk("b2b_first_idx", 200'(first_idx_a), 200'(133));
    chk("b2b_w00", 200'(first_wd_a[7:0]), 200'(8'hFF));
    chk("b2b_w44", 200'(first_wd_a[199:192]), 200'(8'h7B));

    // Reset after 500 pixels; pixel 499 is (15,19), a window
    send_a(500, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("mid_valid_pre", 200'(wv_a), 200'(1));
    reset = 1'b1;
    #1;
    chk_outs_zero("mid_reset");
    iv_a = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    p0 = pulses_a;
    send_a(1024, 1'b0, 0);
    idle_a(4);
    chk("post_rst_pulses", 200'(pulses_a - p0), 200'(784));
    chk("post_rst_first_idx", 200'(first_idx_a), 200'(133));
    chk("post_rst_first", first_wd_a, ramp_first);

    // Small instance: 8x8 ramp, K=3
    p0 = pulses_b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      iv_b = 1'b1;
      d_b = 8'(i);
    end
    @(negedge clk);
    iv_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("small_pulses", 200'(pulses_b - p0), 200'(36));
    chk("small_first_idx", 200'(first_idx_b), 200'(19));
    chk("small_w00", 200'(first_wd_b[7:0]), 200'(0));
    chk("small_w22", 200'(first_wd_b[71:64]), 200'(18));
    chk("small_last_rc", 200'({last_r_b, last_c_b}),
        200'({3'd5, 3'd5}));
    chk("small_last_fd", 200'(last_fd_b), 200'(1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
